// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package ifetch_pkg;

  // Native instruction/address width the fetch entry layout is built for.
  localparam int unsigned XLEN = 32;

  // Sequential fetch increment in bytes.
  localparam int unsigned PC_STEP = 4;

  // RUN issues requests and buffers responses; FLUSH drains stale responses.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ifetch_state_t;

  // One buffered fetch result as seen by decode.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_prefetch_chk.sv
// Protocol checks for the fetch stage: buffer and tag queue never overflow,
// and no response arrives without an outstanding request.
module ifetch_prefetch_chk (
  input logic clk,
  input logic rst,
  input logic i_fifo_push,
  input logic i_fifo_pop,
  input logic i_fifo_full,
  input logic i_tag_push,
  input logic i_tag_pop,
  input logic i_tag_full,
  input logic i_tag_empty
);

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_fifo_push && i_fifo_full && !i_fifo_pop));

  a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_tag_push && i_tag_full && !i_tag_pop));

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    !(i_tag_pop && i_tag_empty));

endmodule

// File: rtl/ifetch_prefetch_sync_fifo.sv
// Small synchronous FIFO with flush, used for the request tag queue and the
// prefetch buffer. DEPTH must be a power of two so pointers wrap naturally.
// Push and pop may coincide at any occupancy, including full.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic [WIDTH-1:0]        i_wdata,
  output logic [WIDTH-1:0]        o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  // An empty queue reads as zero so downstream sees clean outputs.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; unreset because reads of an empty queue are masked.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage with prefetch buffer feeding the IF/ID register.
// Issues sequential PCs under a credit limit (buffered + outstanding <= DEPTH),
// pairs in-order responses with their PCs via a tag queue, and on a taken
// branch flushes the buffer and drops responses still in flight.
// Optional build macro IFETCH_BYPASS_EN: when the buffer is empty a response
// is presented to decode in the same cycle it arrives.
// WIDTH is expected to match ifetch_pkg::XLEN (fetch entry layout).
module ifetch_prefetch #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_en,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             f2d_valid,
  input  logic             f2d_ready,
  output logic [WIDTH-1:0] f2d_instr,
  output logic [WIDTH-1:0] f2d_pc
);

  import ifetch_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  ifetch_state_t    r_state;
  ifetch_state_t    w_state_next;
  logic [WIDTH-1:0] r_fetch_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [CW-1:0]    r_drop_cnt;
  logic [CW-1:0]    w_drop_next;

  logic [CW-1:0]    w_fifo_count;
  logic [CW-1:0]    w_tag_count;
  logic [CW:0]      w_in_use;
  logic             w_credit_ok;
  logic             w_accept;
  logic             w_rsp_keep;
  logic [CW-1:0]    w_redirect_drop;
  logic [WIDTH-1:0] w_redirect_aligned;

  logic             w_fifo_push;
  logic             w_fifo_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [EW-1:0]    w_fifo_rdata;
  logic             w_tag_full;
  logic             w_tag_empty;
  logic [WIDTH-1:0] w_tag_pc;
  logic             w_bypass;

  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head_entry;
  fetch_entry_t     w_out_entry;
  logic             w_out_valid;

  // Credit rule: never have more requests in flight than buffer space.
  assign w_in_use    = {1'b0, w_fifo_count} + {1'b0, w_tag_count};
  assign w_credit_ok = (w_in_use < (CW+1)'(DEPTH));

  assign imem_req_valid = !rst && (r_state == RUN) && w_credit_ok;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_rsp_keep     = imem_rsp_valid && (r_state == RUN);

  // Every response still owed after a redirect belongs to the old stream,
  // including a request accepted on the redirect edge itself.
  assign w_redirect_drop    = w_tag_count + CW'(w_accept) - CW'(imem_rsp_valid);
  assign w_redirect_aligned = redirect_pc & {{(WIDTH-2){1'b1}}, 2'b00};

`ifdef IFETCH_BYPASS_EN
  assign w_bypass = w_fifo_empty && (r_state == RUN) && imem_rsp_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed response taken by decode this cycle never enters the buffer.
  assign w_fifo_push  = w_rsp_keep && !(w_bypass && f2d_ready);
  assign w_fifo_pop   = f2d_ready && !w_fifo_empty;
  assign w_head_entry = fetch_entry_t'(w_fifo_rdata);

  // Assemble the buffer entry from the response and its matching tag.
  always_comb begin
    w_push_entry       = '0;
    w_push_entry.instr = imem_rsp_data;
    w_push_entry.pc    = w_tag_pc;
  end

  // Present either the buffered head or, with bypass, the live response.
  always_comb begin
    w_out_entry = w_head_entry;
    w_out_valid = !w_fifo_empty;
`ifdef IFETCH_BYPASS_EN
    if (w_bypass) begin
      w_out_entry = w_push_entry;
      w_out_valid = 1'b1;
    end else begin
      w_out_entry = w_head_entry;
      w_out_valid = !w_fifo_empty;
    end
`endif
  end

  assign f2d_valid = w_out_valid;
  assign f2d_instr = w_out_entry.instr;
  assign f2d_pc    = w_out_entry.pc;

  // PCs of accepted requests, consumed one per response in order.
  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_pop   (imem_rsp_valid),
    .i_flush (1'b0),
    .i_wdata (r_fetch_pc),
    .o_rdata (w_tag_pc),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_count)
  );

  // Prefetch buffer of {instr, pc} pairs; cleared on redirect.
  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fetch_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_flush (redirect_en),
    .i_wdata (w_push_entry),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  ifetch_prefetch_chk u_chk (
    .clk         (clk),
    .rst         (rst),
    .i_fifo_push (w_fifo_push),
    .i_fifo_pop  (w_fifo_pop),
    .i_fifo_full (w_fifo_full),
    .i_tag_push  (w_accept),
    .i_tag_pop   (imem_rsp_valid),
    .i_tag_full  (w_tag_full),
    .i_tag_empty (w_tag_empty)
  );

  // Next fetch PC, drop count and RUN/FLUSH transitions.
  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop_cnt;
    w_pc_next    = r_fetch_pc;
    if (redirect_en) begin
      w_pc_next    = w_redirect_aligned;
      w_drop_next  = w_redirect_drop;
      w_state_next = (w_redirect_drop != '0) ? FLUSH : RUN;
    end else begin
      if (w_accept) begin
        w_pc_next = r_fetch_pc + WIDTH'(PC_STEP);
      end else begin
        w_pc_next = r_fetch_pc;
      end
      case (r_state)
        RUN: begin
          w_state_next = RUN;
        end
        FLUSH: begin
          if (r_drop_cnt == '0) begin
            w_state_next = RUN;
          end else if (imem_rsp_valid) begin
            w_drop_next  = r_drop_cnt - CW'(1);
            w_state_next = (r_drop_cnt == CW'(1)) ? RUN : FLUSH;
          end else begin
            w_state_next = FLUSH;
          end
        end
        default: begin
          w_state_next = RUN;
        end
      endcase
    end
  end

  // State, fetch PC and drop count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_fetch_pc <= RESET_PC;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_pc_next;
      r_drop_cnt <= w_drop_next;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: a latency-programmable memory model
// feeds responses; a scoreboard queue holds the {pc} stream decode must see.
`timescale 1ns/1ps
module tb_ifetch_prefetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef IFETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        f2d_valid;
  logic        f2d_ready = 1'b0;
  logic [31:0] f2d_instr;
  logic [31:0] f2d_pc;

  ifetch_prefetch #(
    .WIDTH    (32),
    .DEPTH    (4),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .f2d_valid      (f2d_valid),
    .f2d_ready      (f2d_ready),
    .f2d_instr      (f2d_instr),
    .f2d_pc         (f2d_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } mreq_t;

  typedef struct {
    int unsigned lat;
    int unsigned rdy_pct;
    logic [31:0] target;
    logic [31:0] exp_first;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] exq[$];
  vec_t        vecs[5];

  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned ready_pct = 100;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops = 0;
  int          n_acc = 0;
  logic [31:0] m_pc = RST_PC;
  bit          got_first = 1'b0;
  logic [31:0] first_pc = 32'h0;
  bit          s_rsp = 1'b0;
  bit          s_f2d_valid = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive memory side, sample DUT, update model, advance.
  task automatic step();
    bit          rsp_now;
    bit          acc;
    bit          pop;
    mreq_t       e;
    logic [31:0] ex;
    rsp_now        = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? instr_of(mq[0].addr) : 32'h0;
    imem_req_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
    #1;
    acc         = imem_req_valid && imem_req_ready;
    pop         = f2d_valid && f2d_ready;
    s_rsp       = rsp_now;
    s_f2d_valid = f2d_valid;
    if (rsp_now) begin
      e = mq.pop_front();
      if (!e.stale) exq.push_back(e.addr);
    end
    if (pop) begin
      n_pops++;
      if (exq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got pc %h expected none", f2d_pc);
      end else begin
        ex = exq.pop_front();
        chk("f2d_pc", f2d_pc, ex);
        chk("f2d_instr", f2d_instr, instr_of(ex));
      end
      if (!got_first) begin
        got_first = 1'b1;
        first_pc  = f2d_pc;
      end
    end
    if (acc) begin
      n_acc++;
      chk("req_addr", imem_req_addr, m_pc);
      e.addr  = m_pc;
      e.due   = cyc + lat;
      e.stale = 1'b0;
      mq.push_back(e);
      m_pc = m_pc + 32'd4;
    end
    if (redirect_en) begin
      exq.delete();
      for (int i = 0; i < mq.size(); i++) mq[i].stale = 1'b1;
      m_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_first(input string name, input logic [31:0] exp);
    for (int k = 0; k < 60 && !got_first; k++) step();
    chk({name, "_seen"}, {31'b0, got_first}, 32'd1);
    chk({name, "_pc"}, first_pc, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    int p;
    vecs[0] = '{lat: 3, rdy_pct: 100, target: 32'h0000_0200, exp_first: 32'h0000_0200};
    vecs[1] = '{lat: 3, rdy_pct: 100, target: 32'h0000_0203, exp_first: 32'h0000_0200};
    vecs[2] = '{lat: 2, rdy_pct: 60,  target: 32'hFFFF_FFF8, exp_first: 32'hFFFF_FFF8};
    vecs[3] = '{lat: 1, rdy_pct: 100, target: 32'h0000_1001, exp_first: 32'h0000_1000};
    vecs[4] = '{lat: 4, rdy_pct: 50,  target: 32'h0000_0A0E, exp_first: 32'h0000_0A0C};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_f2d_valid", {31'b0, f2d_valid}, 32'd0);
    chk("rst_f2d_instr", f2d_instr, 32'h0);
    chk("rst_f2d_pc", f2d_pc, 32'h0);
    rst = 1'b0;

    // Streaming from reset, memory always ready, latency 1
    lat = 1; ready_pct = 100; f2d_ready = 1'b1; got_first = 1'b0;
    wait_first("stream_first", RST_PC);
    p = n_pops;
    repeat (16) step();
    chk("stream_gapless", n_pops - p, 32'd16);

    // Backpressure: exactly DEPTH new requests, then issue stops
    f2d_ready = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'h0000_0400;
    step();
    redirect_en = 1'b0;
    a = n_acc;
    repeat (10) step();
    chk("bp_accepts", n_acc - a, 32'd4);
    chk("bp_req_valid_low", {31'b0, imem_req_valid}, 32'd0);
    f2d_ready = 1'b1; got_first = 1'b0; p = n_pops;
    repeat (12) step();
    chk("bp_first_pc", first_pc, 32'h0000_0400);
    chk("bp_delivered", {31'b0, (n_pops - p) >= 4}, 32'd1);

    // Table of redirect scenarios
    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat; ready_pct = vecs[i].rdy_pct; f2d_ready = 1'b1;
      repeat (6) step();
      redirect_en = 1'b1; redirect_pc = vecs[i].target;
      step();
      redirect_en = 1'b0; got_first = 1'b0;
      wait_first($sformatf("vec%0d_first", i), vecs[i].exp_first);
      repeat (8) step();
    end

    // Second redirect while still flushing the first
    lat = 3; ready_pct = 100; f2d_ready = 1'b1;
    repeat (6) step();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    redirect_pc = 32'h0000_0300;
    step();
    redirect_en = 1'b0; got_first = 1'b0;
    wait_first("double_redirect", 32'h0000_0300);
    repeat (8) step();

    // Reset with entries buffered
    lat = 1; f2d_ready = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    #1;
    chk("midrst_f2d_valid", {31'b0, f2d_valid}, 32'd0);
    chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("midrst_req_addr", imem_req_addr, RST_PC);
    mq.delete(); exq.delete(); m_pc = RST_PC;
    @(negedge clk);
    rst = 1'b0;

    // Response-to-valid latency with an empty buffer
    s_rsp = 1'b0;
    for (int k = 0; k < 10 && !s_rsp; k++) step();
    chk("lat_rsp_seen", {31'b0, s_rsp}, 32'd1);
    chk("lat_same_cycle", {31'b0, s_f2d_valid}, {31'b0, BYP});
    step();
    chk("lat_next_cycle", {31'b0, s_f2d_valid}, 32'd1);
    f2d_ready = 1'b1; got_first = 1'b0;
    wait_first("restart", RST_PC);
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
